// File: rtl/id_hazard_buffer.sv
// Decode-front block: IF->ID register, stall-proof instruction hold buffer,
// load-use interlock detection and EX>MEM>WB operand forwarding.
module id_hazard_buffer #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int RA_W     = 5,
    parameter int STALL_W  = 6,
    parameter int IF_IDX   = 1,
    parameter int ID_IDX   = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               if_ce,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [31:0]        inst_sram_rdata,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    input  logic               ex_we,
    input  logic               ex_is_load,
    input  logic [RA_W-1:0]    ex_waddr,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic               mem_we,
    input  logic               mem_is_load,
    input  logic [RA_W-1:0]    mem_waddr,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               wb_we,
    input  logic [RA_W-1:0]    wb_waddr,
    input  logic [DATA_W-1:0]  wb_wdata,
    output logic               id_ce,
    output logic [PC_W-1:0]    id_pc,
    output logic [31:0]        id_inst,
    output logic [DATA_W-1:0]  op1,
    output logic [DATA_W-1:0]  op2,
    output logic               stallreq,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic            hold_valid;
    logic [31:0]     hold_inst;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            hz_ex;
    logic            hz_mem;
    logic            stall_if;
    logic            stall_id;
    logic            stall_unused;

    assign stall_if     = stall[IF_IDX];
    assign stall_id     = stall[ID_IDX];
    assign stall_unused = ^stall;

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ce <= 1'b0;
            id_pc <= '0;
        end else if (stall_if && !stall_id) begin
            id_ce <= 1'b0;
            id_pc <= '0;
        end else if (!stall_if) begin
            id_ce <= if_ce;
            id_pc <= if_pc;
        end
    end

    // The SRAM only presents the word for one cycle; capture it on the first stalled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_inst  <= '0;
        end else if (!stall_id) begin
            hold_valid <= 1'b0;
        end else if (!hold_valid) begin
            hold_valid <= 1'b1;
            hold_inst  <= id_inst;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        id_inst = '0;
        if (id_ce) begin
            id_inst = hold_valid ? hold_inst : inst_sram_rdata;
        end
    end

    assign rs = id_inst[25:21];
    assign rt = id_inst[20:16];

    function automatic logic [DATA_W-1:0] fwd(input logic [RA_W-1:0] addr,
                                              input logic [DATA_W-1:0] rf);
        if (addr == '0)                            return rf;
        else if (ex_we && ex_waddr == addr)        return ex_wdata;
        else if (mem_we && mem_waddr == addr)      return mem_wdata;
        else if (wb_we && wb_waddr == addr)        return wb_wdata;
        else                                       return rf;
    endfunction

    always_comb begin
        op1 = fwd(rs, rf_rdata1);
        op2 = fwd(rt, rf_rdata2);
    end

    always_comb begin
        hz_ex  = id_ce && ex_we && ex_is_load && (ex_waddr != '0) &&
                 ((rs_used && rs == ex_waddr) || (rt_used && rt == ex_waddr));
        hz_mem = (LOAD_LAT >= 2) && id_ce && mem_we && mem_is_load && (mem_waddr != '0) &&
                 ((rs_used && rs == mem_waddr) || (rt_used && rt == mem_waddr));
    end

    assign stallreq = hz_ex || hz_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stallreq && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_buffer.sv
// Bench for id_hazard_buffer: three instances (default, LOAD_LAT=2, CNT_W=2)
// compared every cycle against a behavioural model plus directed literal checks.
module tb_id_hazard_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  stall;
    logic        if_ce;
    logic [31:0] if_pc;
    logic [31:0] inst_sram_rdata;
    logic        rs_used, rt_used;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_we, ex_is_load, mem_we, mem_is_load, wb_we;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;

    logic        a_id_ce, b_id_ce, c_id_ce;
    logic [31:0] a_id_pc, b_id_pc, c_id_pc;
    logic [31:0] a_id_inst, b_id_inst, c_id_inst;
    logic [31:0] a_op1, b_op1, c_op1, a_op2, b_op2, c_op2;
    logic        a_stallreq, b_stallreq, c_stallreq;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    id_hazard_buffer dut_a (
        .clk(clk), .rst(rst), .stall(stall), .if_ce(if_ce), .if_pc(if_pc),
        .inst_sram_rdata(inst_sram_rdata), .rs_used(rs_used), .rt_used(rt_used),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .id_ce(a_id_ce), .id_pc(a_id_pc), .id_inst(a_id_inst), .op1(a_op1), .op2(a_op2),
        .stallreq(a_stallreq), .stall_cnt(a_cnt)
    );

    id_hazard_buffer #(.LOAD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .if_ce(if_ce), .if_pc(if_pc),
        .inst_sram_rdata(inst_sram_rdata), .rs_used(rs_used), .rt_used(rt_used),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .id_ce(b_id_ce), .id_pc(b_id_pc), .id_inst(b_id_inst), .op1(b_op1), .op2(b_op2),
        .stallreq(b_stallreq), .stall_cnt(b_cnt)
    );

    id_hazard_buffer #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .if_ce(if_ce), .if_pc(if_pc),
        .inst_sram_rdata(inst_sram_rdata), .rs_used(rs_used), .rt_used(rt_used),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .id_ce(c_id_ce), .id_pc(c_id_pc), .id_inst(c_id_inst), .op1(c_op1), .op2(c_op2),
        .stallreq(c_stallreq), .stall_cnt(c_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the ID stage must hold, derived from the stall rules.
    logic        m_started = 1'b0;
    logic        m_ce;
    logic [31:0] m_pc;
    logic        m_hv;
    logic [31:0] m_hi;
    int          m_cnt [3];
    int          m_max [3] = '{65535, 65535, 3};
    int          m_lat [3] = '{1, 2, 1};

    function automatic logic [31:0] m_inst();
        if (!m_ce) return 32'h0;
        return m_hv ? m_hi : inst_sram_rdata;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
        if (ex_we && ex_waddr == a) return ex_wdata;
        if (mem_we && mem_waddr == a) return mem_wdata;
        if (wb_we && wb_waddr == a) return wb_wdata;
        return rf;
    endfunction

    function automatic logic m_hz(input logic we, input logic isl, input logic [4:0] wa);
        logic [31:0] i;
        i = m_inst();
        return m_ce && we && isl && (wa != 5'd0) &&
               ((rs_used && i[25:21] == wa) || (rt_used && i[20:16] == wa));
    endfunction

    function automatic logic m_stallreq(input int lat);
        return m_hz(ex_we, ex_is_load, ex_waddr) ||
               (lat == 2 && m_hz(mem_we, mem_is_load, mem_waddr));
    endfunction

    always @(posedge clk) begin
        m_started <= 1'b1;
        if (rst) begin
            m_ce <= 1'b0;
            m_pc <= 32'h0;
            m_hv <= 1'b0;
            m_hi <= 32'h0;
            for (int k = 0; k < 3; k++) m_cnt[k] <= 0;
        end else begin
            if (!stall[1]) begin
                m_ce <= if_ce;
                m_pc <= if_pc;
            end else if (!stall[2]) begin
                m_ce <= 1'b0;
                m_pc <= 32'h0;
            end
            if (!stall[2]) m_hv <= 1'b0;
            else if (!m_hv) begin
                m_hv <= 1'b1;
                m_hi <= m_inst();
            end
            for (int k = 0; k < 3; k++)
                if (m_stallreq(m_lat[k]) && m_cnt[k] < m_max[k]) m_cnt[k] <= m_cnt[k] + 1;
        end
    end

    always @(negedge clk) begin : cmp
        logic [31:0] ci;
        if (m_started) begin
            ci = m_inst();
            check("cyc id_ce", 32'(a_id_ce), 32'(m_ce));
            check("cyc id_pc", a_id_pc, m_pc);
            check("cyc id_inst", a_id_inst, ci);
            if (!m_hz(ex_we, ex_is_load, ex_waddr)) begin
                check("cyc op1", a_op1, m_fwd(ci[25:21], rf_rdata1));
                check("cyc op2", a_op2, m_fwd(ci[20:16], rf_rdata2));
            end
            check("cyc stallreq_a", 32'(a_stallreq), 32'(m_stallreq(m_lat[0])));
            check("cyc stallreq_b", 32'(b_stallreq), 32'(m_stallreq(m_lat[1])));
            check("cyc stallreq_c", 32'(c_stallreq), 32'(m_stallreq(m_lat[2])));
            check("cyc cnt_a", 32'(a_cnt), 32'(m_cnt[0]));
            check("cyc cnt_b", 32'(b_cnt), 32'(m_cnt[1]));
            check("cyc cnt_c", 32'(c_cnt), 32'(m_cnt[2]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        stall = '0; if_ce = 1'b0; if_pc = '0; inst_sram_rdata = '0;
        rs_used = 1'b0; rt_used = 1'b0;
        rf_rdata1 = 32'h1111_1111; rf_rdata2 = 32'h2222_2222;
        ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
        mem_we = 1'b0; mem_is_load = 1'b0; mem_waddr = '0; mem_wdata = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    endtask

    task automatic random_inputs();
        stall = 6'($urandom); if_ce = 1'($urandom); if_pc = $urandom;
        inst_sram_rdata = $urandom; rs_used = 1'($urandom); rt_used = 1'($urandom);
        rf_rdata1 = $urandom; rf_rdata2 = $urandom;
        ex_we = 1'($urandom); ex_is_load = 1'($urandom); ex_waddr = 5'($urandom); ex_wdata = $urandom;
        mem_we = 1'($urandom); mem_is_load = 1'($urandom); mem_waddr = 5'($urandom); mem_wdata = $urandom;
        wb_we = 1'($urandom); wb_waddr = 5'($urandom); wb_wdata = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        random_inputs();
        tick();
        random_inputs();
        tick();
        rst = 1'b0;
        idle();
        if_ce = 1'b1; if_pc = 32'hBFC0_0000; inst_sram_rdata = 32'h3C01_1234;
        sample();
        check("rst id_ce", 32'(a_id_ce), 32'h0);
        check("rst id_inst", a_id_inst, 32'h0);
        check("rst stallreq", 32'(a_stallreq), 32'h0);
        check("rst stall_cnt", 32'(a_cnt), 32'h0);

        tick();
        sample();
        check("fetch id_pc", a_id_pc, 32'hBFC0_0000);
        check("fetch id_ce", 32'(a_id_ce), 32'h1);
        check("fetch id_inst", a_id_inst, 32'h3C01_1234);

        // load-use on rs=$1 held through a three-cycle stall
        tick();
        inst_sram_rdata = 32'h0022_1821; rs_used = 1'b1; rt_used = 1'b1;
        ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'hDEAD_BEEF;
        stall = 6'b000111;
        sample();
        check("lu stallreq", 32'(a_stallreq), 32'h1);
        check("lu id_inst", a_id_inst, 32'h0022_1821);
        tick();
        inst_sram_rdata = 32'hFFFF_FFFF;
        sample();
        check("hold id_inst", a_id_inst, 32'h0022_1821);
        tick();
        sample();
        tick();
        stall = '0; ex_we = 1'b0; ex_is_load = 1'b0;
        sample();
        check("hold id_inst end", a_id_inst, 32'h0022_1821);
        check("hold stall_cnt", 32'(a_cnt), 32'd3);

        // forwarding priority on rs=5
        tick();
        inst_sram_rdata = 32'h00A6_3021;
        ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hA;
        mem_we = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'hB;
        wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hC;
        sample();
        check("fwd ex", a_op1, 32'hA);
        check("fwd op2 rf", a_op2, 32'h2222_2222);
        tick();
        ex_we = 1'b0;
        sample();
        check("fwd mem", a_op1, 32'hB);
        tick();
        ex_we = 1'b1; mem_we = 1'b0;
        sample();
        check("fwd ex over wb", a_op1, 32'hA);
        tick();
        mem_we = 1'b1; wb_waddr = 5'd6;
        ex_waddr = 5'd0; mem_waddr = 5'd0;
        sample();
        check("fwd wb op2", a_op2, 32'hC);
        check("fwd miss op1", a_op1, 32'h1111_1111);
        tick();
        inst_sram_rdata = 32'h0006_3021; wb_waddr = 5'd0;
        sample();
        check("fwd zero op1", a_op1, 32'h1111_1111);

        // MEM load-use only matters with LOAD_LAT=2
        tick();
        inst_sram_rdata = 32'h0007_3021; rs_used = 1'b0; rt_used = 1'b1;
        ex_we = 1'b0; wb_we = 1'b0;
        mem_we = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h2222;
        sample();
        check("lat2 stallreq", 32'(b_stallreq), 32'h1);
        check("lat1 stallreq", 32'(a_stallreq), 32'h0);
        check("lat1 op2", a_op2, 32'h2222);

        // bubble beats a pending stall request
        tick();
        stall = 6'b000010;
        sample();
        check("pre-bubble lat2", 32'(b_stallreq), 32'h1);
        tick();
        stall = '0; if_pc = 32'hBFC0_0010;
        sample();
        check("bubble id_ce", 32'(a_id_ce), 32'h0);
        check("bubble id_inst", a_id_inst, 32'h0);
        check("bubble lat2", 32'(b_stallreq), 32'h0);

        // reset in the middle of a held stall clears the hold buffer
        tick();
        mem_we = 1'b0; mem_is_load = 1'b0;
        inst_sram_rdata = 32'h0022_1821; stall = 6'b000111;
        sample();
        check("mid id_pc", a_id_pc, 32'hBFC0_0010);
        check("mid id_inst", a_id_inst, 32'h0022_1821);
        tick();
        rst = 1'b1; inst_sram_rdata = 32'hFFFF_FFFF;
        sample();
        check("mid hold", a_id_inst, 32'h0022_1821);
        tick();
        rst = 1'b0; stall = 6'b000100;
        sample();
        check("mid rst id_ce", 32'(a_id_ce), 32'h0);
        check("mid rst id_inst", a_id_inst, 32'h0);
        check("mid rst cnt", 32'(a_cnt), 32'h0);
        tick();
        stall = '0;
        sample();
        check("post rst id_ce", 32'(a_id_ce), 32'h1);
        check("post rst capture", a_id_inst, 32'h0);
        tick();
        sample();
        check("post rst sram", a_id_inst, 32'hFFFF_FFFF);

        // counter saturation over five stall-request cycles
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inst_sram_rdata = 32'h0022_1821; rs_used = 1'b1; rt_used = 1'b0;
        ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd1;
        sample();
        check("sat pre stallreq", 32'(a_stallreq), 32'h0);
        tick();
        sample();
        check("sat stallreq", 32'(a_stallreq), 32'h1);
        repeat (5) tick();
        ex_we = 1'b0;
        sample();
        check("sat cnt16", 32'(a_cnt), 32'd5);
        check("sat cnt2", 32'(c_cnt), 32'd3);
        check("sat cnt lat2", 32'(b_cnt), 32'd5);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
